// File: rtl/stall_ctrl_if.sv
// Hazard / MDU stall control handshake bundle.
// master drives the pipeline-side inputs, slave is the stall controller.
interface stall_ctrl_if;
  logic       req;
  logic       start_e;
  logic       md_type_e;
  logic       md_use_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic       regwrite_e;
  logic [4:0] dst_e;
  logic [1:0] tnew_e;
  logic       regwrite_m;
  logic [4:0] dst_m;
  logic [1:0] tnew_m;
  logic       stall;
  logic       flush_all;
  logic       md_busy;
  logic [3:0] md_cnt;

  modport master (
    output req, start_e, md_type_e, md_use_d,
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d,
    output regwrite_e, dst_e, tnew_e,
    output regwrite_m, dst_m, tnew_m,
    input  stall, flush_all, md_busy, md_cnt
  );

  modport slave (
    input  req, start_e, md_type_e, md_use_d,
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d,
    input  regwrite_e, dst_e, tnew_e,
    input  regwrite_m, dst_m, tnew_m,
    output stall, flush_all, md_busy, md_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush control with MDU busy counter.
// Optional: STALL_CTRL_REQ_FLUSH_EN enables req-driven flush.
module stall_ctrl (
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  sif
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       busy;
  logic       kill;

  logic haz_rs_e, haz_rs_m;
  logic haz_rt_e, haz_rt_m;
  logic md_stall, raw_stall;

`ifdef STALL_CTRL_REQ_FLUSH_EN
  assign kill          = sif.req;
  assign sif.flush_all = sif.req & ~reset;
`else
  assign kill          = 1'b0;
  assign sif.flush_all = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (sif.start_e) begin
          state <= BUSY;
          cnt   <= sif.md_type_e ? 4'd10 : 4'd5;
          busy  <= 1'b1;
        end
        BUSY: if (cnt <= 4'd1) begin
          state <= IDLE;
          cnt   <= 4'd0;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign haz_rs_e = (sif.rs_d != 5'd0) & sif.regwrite_e
                  & (sif.dst_e == sif.rs_d)
                  & (sif.tuse_rs_d < sif.tnew_e);
  assign haz_rs_m = (sif.rs_d != 5'd0) & sif.regwrite_m
                  & (sif.dst_m == sif.rs_d)
                  & (sif.tuse_rs_d < sif.tnew_m);
  assign haz_rt_e = (sif.rt_d != 5'd0) & sif.regwrite_e
                  & (sif.dst_e == sif.rt_d)
                  & (sif.tuse_rt_d < sif.tnew_e);
  assign haz_rt_m = (sif.rt_d != 5'd0) & sif.regwrite_m
                  & (sif.dst_m == sif.rt_d)
                  & (sif.tuse_rt_d < sif.tnew_m);

  assign md_stall  = sif.md_use_d & (sif.start_e | busy);
  assign raw_stall = md_stall | haz_rs_e | haz_rs_m
                   | haz_rt_e | haz_rt_m;

  // A flush outranks any stall so the redirect is not held off.
  assign sif.stall   = raw_stall & ~kill;
  assign sif.md_busy = busy;
  assign sif.md_cnt  = cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl.
// Covers MDU counting, data hazards, reset abort and req handling.
module tb_stall_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  stall_ctrl_if sif ();

  stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sif.req        = 1'b0;
    sif.start_e    = 1'b0;
    sif.md_type_e  = 1'b0;
    sif.md_use_d   = 1'b0;
    sif.rs_d       = 5'd0;
    sif.rt_d       = 5'd0;
    sif.tuse_rs_d  = 2'd3;
    sif.tuse_rt_d  = 2'd3;
    sif.regwrite_e = 1'b0;
    sif.dst_e      = 5'd0;
    sif.tnew_e     = 2'd0;
    sif.regwrite_m = 1'b0;
    sif.dst_m      = 5'd0;
    sif.tnew_m     = 2'd0;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    // Reset wins over start_e and req.
    sif.start_e = 1'b1;
    sif.req     = 1'b1;
    #1;
    chk("rst_flush", 32'(sif.flush_all), 32'd0);
    tick();
    tick();
    chk("rst_flush2", 32'(sif.flush_all), 32'd0);
    chk("rst_cnt", 32'(sif.md_cnt), 32'd0);
    chk("rst_busy", 32'(sif.md_busy), 32'd0);
    idle_in();
    reset = 1'b0;
    #1;
    chk("idle_stall", 32'(sif.stall), 32'd0);
    tick();
    chk("idle_cnt", 32'(sif.md_cnt), 32'd0);

    // Mult: busy cycles 1..5, counting 5..1.
    sif.start_e   = 1'b1;
    sif.md_type_e = 1'b0;
    tick();
    sif.start_e = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("mul_cnt%0d", i), 32'(sif.md_cnt), 32'(6 - i));
      chk($sformatf("mul_busy%0d", i), 32'(sif.md_busy), 32'd1);
      tick();
    end
    chk("mul_end_cnt", 32'(sif.md_cnt), 32'd0);
    chk("mul_end_busy", 32'(sif.md_busy), 32'd0);

    // start_e while busy is ignored.
    sif.start_e = 1'b1;
    tick();
    sif.md_type_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ign_cnt%0d", i), 32'(sif.md_cnt), 32'(5 - i));
      tick();
    end
    sif.start_e = 1'b0;
    tick();
    tick();
    chk("ign_end", 32'(sif.md_cnt), 32'd0);

    // Div with D using the MDU: stall cycles 0..10.
    sif.md_use_d  = 1'b1;
    sif.start_e   = 1'b1;
    sif.md_type_e = 1'b1;
    #1;
    chk("div_stall0", 32'(sif.stall), 32'd1);
    tick();
    sif.start_e = 1'b0;
    #1;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("div_stall%0d", i), 32'(sif.stall), 32'd1);
      chk($sformatf("div_cnt%0d", i), 32'(sif.md_cnt), 32'(11 - i));
      tick();
    end
    chk("div_stall11", 32'(sif.stall), 32'd0);
    chk("div_cnt11", 32'(sif.md_cnt), 32'd0);
    idle_in();

    // E-stage rs hazard.
    sif.regwrite_e = 1'b1;
    sif.dst_e      = 5'd5;
    sif.tnew_e     = 2'd2;
    sif.rs_d       = 5'd5;
    sif.tuse_rs_d  = 2'd1;
    #1;
    chk("haz_rs_e", 32'(sif.stall), 32'd1);
    sif.rs_d = 5'd0;
    #1;
    chk("haz_rs_r0", 32'(sif.stall), 32'd0);
    sif.rs_d      = 5'd5;
    sif.tuse_rs_d = 2'd3;
    #1;
    chk("haz_rs_tu3", 32'(sif.stall), 32'd0);
    sif.tuse_rs_d = 2'd2;
    #1;
    chk("haz_rs_eq", 32'(sif.stall), 32'd0);
    sif.tuse_rs_d  = 2'd1;
    sif.regwrite_e = 1'b0;
    #1;
    chk("haz_rs_nowe", 32'(sif.stall), 32'd0);
    idle_in();

    // M-stage rt hazard.
    sif.regwrite_m = 1'b1;
    sif.dst_m      = 5'd7;
    sif.tnew_m     = 2'd1;
    sif.rt_d       = 5'd7;
    sif.tuse_rt_d  = 2'd0;
    #1;
    chk("haz_rt_m", 32'(sif.stall), 32'd1);
    sif.tuse_rt_d = 2'd1;
    #1;
    chk("haz_rt_m_ok", 32'(sif.stall), 32'd0);
    sif.tuse_rt_d = 2'd0;
    sif.dst_m     = 5'd6;
    #1;
    chk("haz_rt_m_dst", 32'(sif.stall), 32'd0);
    idle_in();
    tick();

    // Reset at cycle 4 of a div aborts it.
    sif.start_e   = 1'b1;
    sif.md_type_e = 1'b1;
    tick();
    sif.start_e = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pre", 32'(sif.md_cnt), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_cnt", 32'(sif.md_cnt), 32'd0);
    chk("abort_busy", 32'(sif.md_busy), 32'd0);
    sif.start_e   = 1'b1;
    sif.md_type_e = 1'b0;
    tick();
    sif.start_e = 1'b0;
    chk("abort_mul", 32'(sif.md_cnt), 32'd5);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_drain", 32'(sif.md_cnt), 32'd0);

    // req during a div.
    sif.md_use_d  = 1'b1;
    sif.start_e   = 1'b1;
    sif.md_type_e = 1'b1;
    tick();
    sif.start_e = 1'b0;
    tick();
    tick();
    sif.req = 1'b1;
    #1;
`ifdef STALL_CTRL_REQ_FLUSH_EN
    chk("req_flush", 32'(sif.flush_all), 32'd1);
    chk("req_stall", 32'(sif.stall), 32'd0);
    tick();
    sif.req = 1'b0;
    chk("req_busy", 32'(sif.md_busy), 32'd0);
    chk("req_cnt", 32'(sif.md_cnt), 32'd0);
    // start_e together with req is dropped.
    sif.start_e = 1'b1;
    sif.req     = 1'b1;
    tick();
    sif.start_e = 1'b0;
    sif.req     = 1'b0;
    chk("req_start", 32'(sif.md_busy), 32'd0);
`else
    chk("req_flush", 32'(sif.flush_all), 32'd0);
    chk("req_stall", 32'(sif.stall), 32'd1);
    tick();
    sif.req = 1'b0;
    chk("req_busy", 32'(sif.md_busy), 32'd1);
    chk("req_cnt", 32'(sif.md_cnt), 32'd7);
`endif
    idle_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 clk  input  1  clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req  input  1  exception/interrupt request; pipeline flush command.
REQ-004 start_e  input  1  mult/div instruction valid in E this cycle.
REQ-005 md_type_e  input  1  0 = mult(u), 1 = div(u).
REQ-006 md_use_d  input  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-007 rs_d, rt_d  input  5 each  D-stage source register numbers.
REQ-008 tuse_rs_d, tuse_rt_d  input  2 each  cycles until D needs the operand; 3 = not used.
REQ-009 regwrite_e, dst_e, tnew_e  input  1/5/2  E-stage write enable, destination and Tnew.
REQ-010 regwrite_m, dst_m, tnew_m  input  1/5/2  M-stage write enable, destination and Tnew.
REQ-011 stall  output  1  freezes PC and IF/ID; bubbles ID/EX.
REQ-012 flush_all  output  1  clears every pipeline register, including the M/W register.
REQ-013 md_busy  output  1  MDU busy.
REQ-014 md_cnt  output  4  remaining MDU busy cycles.

Function
REQ-015 State machine SHALL have exactly two states: IDLE and BUSY.
REQ-016 In IDLE, start_e=1 SHALL load md_cnt with 5 (mult) or 10 (div) and enter BUSY on the next edge.
REQ-017 In BUSY, md_cnt SHALL decrement by 1 each cycle; at md_cnt=1 the next edge SHALL give md_cnt=0 and IDLE.
REQ-018 md_busy SHALL equal (state==BUSY), registered; a mult issued in cycle t gives md_busy=1 in cycles t+1..t+5.
REQ-019 start_e asserted while BUSY SHALL be ignored; md_cnt continues counting down.
REQ-020 md_stall SHALL be md_use_d & (start_e | md_busy), combinational.
REQ-021 rs hazard in E SHALL be rs_d!=0 & regwrite_e & dst_e==rs_d & tuse_rs_d<tnew_e.
REQ-022 rs hazard in M SHALL be rs_d!=0 & regwrite_m & dst_m==rs_d & tuse_rs_d<tnew_m.
REQ-023 rt hazards SHALL use the same rules as REQ-021/022 with rt_d and tuse_rt_d.
REQ-024 stall SHALL be the OR of md_stall and all four data hazards, gated by REQ-029.
REQ-025 Register 0 SHALL never cause a hazard; tuse=3 SHALL never stall.
REQ-026 md_cnt SHALL never wrap below 0 and SHALL never exceed 10.

Reset
REQ-027 With reset=1 at an edge, the next state SHALL be IDLE with md_cnt=0 and md_busy=0, regardless of start_e or req.
REQ-028 During reset, stall SHALL be driven only by the combinational hazard terms. flush_all SHALL equal 0 while reset=1. Reset during BUSY SHALL abort the operation.

Configuration
REQ-029 With macro STALL_CTRL_REQ_FLUSH_EN defined:
- flush_all = req.
- stall is forced to 0 when req=1.
- req=1 at an edge forces IDLE with md_cnt=0.
- start_e in the same cycle as req is ignored.
REQ-030 With STALL_CTRL_REQ_FLUSH_EN undefined:
- flush_all is tied to 0.
- req is unused.
- The MDU counter is unaffected by req.

Verification
REQ-031 Pulse start_e=1 with md_type_e=0 at cycle 0 -> md_busy=1 for cycles 1-5, md_cnt=5,4,3,2,1, then 0 and IDLE at cycle 6.
REQ-032 Issue a div, then hold md_use_d=1 -> stall=1 from cycle 0 through cycle 10, and stall=0 at cycle 11.
REQ-033 dst_e=5, regwrite_e=1, tnew_e=2, rs_d=5, tuse_rs_d=1 -> stall=1. Same stimulus with rs_d=0 or tuse_rs_d=3 -> stall=0.
REQ-034 dst_m=7, regwrite_m=1, tnew_m=1, rt_d=7, tuse_rt_d=0 -> stall=1. With tuse_rt_d=1 -> stall=0.
REQ-035 (STALL_CTRL_REQ_FLUSH_EN) Issue a div, assert req at cycle 3 -> flush_all=1 and stall=0 in cycle 3; md_busy=0 and md_cnt=0 at cycle 4.
REQ-036 Assert reset in cycle 4 of a div -> md_cnt=0 and md_busy=0 in the next cycle; a new mult issued afterwards counts from 5.
